grid_pixel_sampler: RTL

GRID_PIXEL_SAMPLER -- requirements
Module: grid_pixel_sampler

---
 rtl/grid_pixel_sampler_pkg.sv | 19 +
 rtl/grid_pixel_sampler_matcher.sv | 27 ++
 rtl/grid_pixel_sampler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/grid_pixel_sampler_pkg.sv
// Shared definitions for the grid pixel sampler: FSM encoding and sample-grid geometry.
package grid_pixel_sampler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Centre of grid cell idx when a span of size pixels is split into grid cells.
  function automatic int sample_pos(input int idx, input int size, input int grid);
    return ((2 * idx + 1) * size) / (2 * grid);
  endfunction

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grid_pixel_sampler_matcher.sv
// Maps a line or column counter onto the sample grid: hit when it sits on a sample position.
// Purely combinational; one instance for lines, one for columns.
module grid_matcher
  import grid_pixel_sampler_pkg::*;
#(
  parameter int N    = 7,
  parameter int SIZE = 120,
  parameter int GRID = 3,
  localparam int IW  = width_of(GRID)
) (
  input  logic [N-1:0]  value,
  output logic          hit,
  output logic [IW-1:0] idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int g = 0; g < GRID; g++) begin
      if (value == N'(sample_pos(g, SIZE, GRID))) begin
        hit = 1'b1;
        idx = IW'(g);
      end
    end
  end

endmodule

// File: rtl/grid_pixel_sampler.sv
// Captures one frame of 16-bit pixels from a byte stream and keeps a GRID_L x GRID_C sample grid.
// Samples land one cycle after their second byte; rd_data is registered (one-cycle read latency).
module grid_pixel_sampler
  import grid_pixel_sampler_pkg::*;
#(
  parameter int LINES    = 120,
  parameter int COLUMNS  = 320,
  parameter int GRID_L   = 3,
  parameter int GRID_C   = 3,
  parameter int HI_FIRST = 1,
  localparam int S_LINE   = width_of(LINES),
  localparam int S_COLUMN = width_of(COLUMNS),
  localparam int NS       = GRID_L * GRID_C,
  localparam int S_ADDR   = width_of(NS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  input  logic [S_ADDR-1:0]   rd_addr,
  output logic                busy,
  output logic                done,
  output logic                sample_we,
  output logic [NS-1:0]       valid_mask,
  output logic [15:0]         rd_data,
  output logic [S_LINE-1:0]   db_line,
  output logic [S_COLUMN-1:0] db_column
);

  localparam int LW = width_of(GRID_L);
  localparam int CW = width_of(GRID_C);

  state_t                state, state_nx;
  logic [S_LINE-1:0]     line;
  logic [S_COLUMN-1:0]   column;
  logic                  phase;
  logic [7:0]            first_byte;
  logic [15:0]           mem [NS];

  logic                  line_hit, col_hit;
  logic [LW-1:0]         line_idx;
  logic [CW-1:0]         col_idx;
  logic                  take, pix_done, last_col, last_line, frame_end, wr_en;
  logic [15:0]           pixel;
  logic [S_ADDR-1:0]     wr_addr;

  grid_matcher #(.N(S_LINE), .SIZE(LINES), .GRID(GRID_L)) u_line_match (
    .value (line),
    .hit   (line_hit),
    .idx   (line_idx)
  );

  grid_matcher #(.N(S_COLUMN), .SIZE(COLUMNS), .GRID(GRID_C)) u_col_match (
    .value (column),
    .hit   (col_hit),
    .idx   (col_idx)
  );

  // abort outranks a byte arriving in the same cycle
  assign take      = (state == ST_CAPTURE) && byte_valid && !abort;
  assign pix_done  = take && phase;
  assign last_col  = (column == S_COLUMN'(COLUMNS - 1));
  assign last_line = (line == S_LINE'(LINES - 1));
  assign frame_end = pix_done && last_col && last_line;
  assign pixel     = (HI_FIRST != 0) ? {first_byte, byte_data} : {byte_data, first_byte};
  assign wr_en     = pix_done && line_hit && col_hit;
  assign wr_addr   = S_ADDR'(int'(line_idx) * GRID_C + int'(col_idx));

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (start) state_nx = ST_CAPTURE;
      ST_CAPTURE: begin
        if (abort)          state_nx = ST_IDLE;
        else if (frame_end) state_nx = ST_DONE;
      end
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      line       <= '0;
      column     <= '0;
      phase      <= 1'b0;
      first_byte <= '0;
      valid_mask <= '0;
      sample_we  <= 1'b0;
    end else begin
      sample_we <= wr_en;
      if (state == ST_IDLE && start) begin
        line       <= '0;
        column     <= '0;
        phase      <= 1'b0;
        valid_mask <= '0;
      end else if (state == ST_CAPTURE && abort) begin
        line   <= '0;
        column <= '0;
        phase  <= 1'b0;
      end else if (take) begin
        if (!phase) begin
          first_byte <= byte_data;
          phase      <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (last_col) begin
            column <= '0;
            line   <= last_line ? '0 : line + 1'b1;
          end else begin
            column <= column + 1'b1;
          end
          if (wr_en) valid_mask[wr_addr] <= 1'b1;
        end
      end
    end
  end

  // Sample storage is deliberately not reset; valid_mask says what is live.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= pixel;
  end

  always_ff @(posedge clock) begin
    if (reset)                   rd_data <= '0;
    else if (int'(rd_addr) < NS) rd_data <= mem[rd_addr];
    else                         rd_data <= '0;
  end

  assign busy      = (state == ST_CAPTURE);
  assign done      = (state == ST_DONE);
  assign db_line   = line;
  assign db_column = column;

endmodule
